// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the baud divider helper for the 16x UART receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  typedef struct packed {
    logic [UART_DATA_W-1:0] data;
    logic                   valid;
    logic                   frame_err;
    logic                   brk;
  } rx_rsp_t;

  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-side result bus of uart_rx_os16; o_parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_os16_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] o_data;
  logic                   o_valid;
  logic                   o_frame_err;
  logic                   o_break;
  logic                   o_busy;
`ifdef UART_RX_PARITY_EN
  logic                   o_parity_err;
`endif

  modport master (
    output o_data, o_valid, o_frame_err, o_break, o_busy
`ifdef UART_RX_PARITY_EN
    , output o_parity_err
`endif
  );

  modport slave (
    input o_data, o_valid, o_frame_err, o_break, o_busy
`ifdef UART_RX_PARITY_EN
    , input o_parity_err
`endif
  );

endinterface

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1, pulses at DIV-1, synchronous clear re-phases it.
module uart_os_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling 8N1 UART receiver with majority vote, framing and break detection.
// Optional even/odd parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_rx,
  uart_rx_os16_if.master rx_if
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  logic [1:0]             sync_q, sync_d;
  logic                   rx_prev_q, rx_s;
  logic [2:0]             state_q, state_d;
  logic [OSW-1:0]         os_cnt_q, os_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]             v_q, v_d;
  logic                   idle_ok_q, idle_ok_d;
  rx_rsp_t                rsp_q, rsp_d;
  logic                   tick, clr, decide, vote;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d, perr_q, perr_d;
`endif

  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], i_rx};
  assign decide = tick && (os_cnt_q == OSW'(M + 1));
  assign vote   = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    v_d       = v_q;
    idle_ok_d = idle_ok_q;
    clr       = 1'b0;
    rsp_d           = rsp_q;
    rsp_d.valid     = 1'b0;
    rsp_d.frame_err = 1'b0;
    rsp_d.brk       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d  = par_q;
    perr_d = 1'b0;
`endif
    os_cnt_d = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    if (tick && os_cnt_q == OSW'(M - 1)) v_d[0] = rx_s;
    if (tick && os_cnt_q == OSW'(M))     v_d[1] = rx_s;

    case (state_q)
      IDLE: if (rx_prev_q && !rx_s) begin
        // Re-phase tick and oversample counters to the start edge.
        clr      = 1'b1;
        os_cnt_d = '0;
        state_d  = START;
      end
      START: if (decide) begin
        state_d   = vote ? IDLE : DATA;
        bit_cnt_d = '0;
      end
      DATA: if (decide) begin
        shreg_d   = {vote, shreg_q[UART_DATA_W-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
        if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (decide) begin
        par_d   = vote;
        state_d = STOP;
      end
`endif
      STOP: if (decide) begin
        if (vote) begin
          rsp_d.data  = shreg_q;
          rsp_d.valid = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d = par_q != ((^shreg_q) ^ PARITY_ODD[0]);
`endif
          state_d = IDLE;
        end else begin
          rsp_d.frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          rsp_d.brk = (shreg_q == '0) && !par_q;
`else
          rsp_d.brk = (shreg_q == '0);
`endif
          idle_ok_d = 1'b0;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Leave only after the line stayed high across a whole tick interval.
        if (!rx_s) idle_ok_d = 1'b0;
        else if (tick) begin
          if (idle_ok_q) state_d = IDLE;
          idle_ok_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      v_q       <= '0;
      idle_ok_q <= 1'b0;
      rsp_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      v_q       <= v_d;
      idle_ok_q <= idle_ok_d;
      rsp_q     <= rsp_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_if.o_data      = rsp_q.data;
  assign rx_if.o_valid     = rsp_q.valid;
  assign rx_if.o_frame_err = rsp_q.frame_err;
  assign rx_if.o_break     = rsp_q.brk;
  assign rx_if.o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at DIV=10 (1 bit = 160 clk); strobes are counted by a monitor.
module tb_uart_rx_os16;

  localparam int BIT = 160;

  logic clk, rst_n, i_rx;
  uart_rx_os16_if rx_if ();

  uart_rx_os16 #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16),
    .PARITY_ODD (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rx  (i_rx),
    .rx_if (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, n_brk = 0, n_brk_ferr = 0, n_perr_valid = 0;
  int last_valid = 0, prev_valid = 0;

  always @(negedge clk) begin
    cyc++;
    if (rx_if.o_valid) begin
      n_valid++;
      prev_valid = last_valid;
      last_valid = cyc;
    end
    if (rx_if.o_frame_err) n_ferr++;
    if (rx_if.o_break) n_brk++;
    if (rx_if.o_break && rx_if.o_frame_err) n_brk_ferr++;
`ifdef UART_RX_PARITY_EN
    if (rx_if.o_parity_err && rx_if.o_valid) n_perr_valid++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  // glitch: data bit index that gets a 1-clk inverted pulse at mid-bit (-1 = none)
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch, input logic par_ok);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        send_bit(d[i], 80);
        send_bit(~d[i], 1);
        send_bit(d[i], 79);
      end else send_bit(d[i], BIT);
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok, BIT);
`else
    if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
    send_bit(stop, BIT);
    i_rx = 1'b1;
  endtask

  int v0, f0, b0, bf0, p0;
  task automatic snap();
    v0 = n_valid; f0 = n_ferr; b0 = n_brk; bf0 = n_brk_ferr; p0 = n_perr_valid;
  endtask

  initial begin
    i_rx  = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data",  32'(rx_if.o_data), 32'h00);
    chk("rst_valid", 32'(rx_if.o_valid), 32'd0);
    chk("rst_ferr",  32'(rx_if.o_frame_err), 32'd0);
    chk("rst_brk",   32'(rx_if.o_break), 32'd0);
    chk("rst_busy",  32'(rx_if.o_busy), 32'd0);
    rst_n = 1'b1;
    send_bit(1'b1, 200);

    // plain frame
    snap();
    send_frame(8'h61, 1'b1, -1, 1'b1);
    chk("f61_busy_after_stop", 32'(rx_if.o_busy), 32'd0);
    send_bit(1'b1, 100);
    chk("f61_nvalid", 32'(n_valid - v0), 32'd1);
    chk("f61_data",   32'(rx_if.o_data), 32'h61);
    chk("f61_nferr",  32'(n_ferr - f0), 32'd0);
    chk("f61_nbrk",   32'(n_brk - b0), 32'd0);

    // false start
    snap();
    send_bit(1'b0, 40);
    send_bit(1'b1, 300);
    chk("fs_nvalid", 32'(n_valid - v0), 32'd0);
    chk("fs_nferr",  32'(n_ferr - f0), 32'd0);
    chk("fs_busy",   32'(rx_if.o_busy), 32'd0);
    chk("fs_data",   32'(rx_if.o_data), 32'h61);

    // glitch in data bit 3
    snap();
    send_frame(8'hA5, 1'b1, 3, 1'b1);
    send_bit(1'b1, 100);
    chk("gl_nvalid", 32'(n_valid - v0), 32'd1);
    chk("gl_data",   32'(rx_if.o_data), 32'hA5);

    // framing error
    snap();
    send_frame(8'h55, 1'b0, -1, 1'b1);
    send_bit(1'b1, 2*BIT);
    chk("fe_nferr",  32'(n_ferr - f0), 32'd1);
    chk("fe_nvalid", 32'(n_valid - v0), 32'd0);
    chk("fe_nbrk",   32'(n_brk - b0), 32'd0);
    chk("fe_data",   32'(rx_if.o_data), 32'hA5);
    chk("fe_busy",   32'(rx_if.o_busy), 32'd0);

    // break: line low for three frames, then recovery
    snap();
    send_bit(1'b0, 30*BIT);
    chk("brk_busy_low", 32'(rx_if.o_busy), 32'd1);
    send_bit(1'b1, 2*BIT);
    chk("brk_nferr",   32'(n_ferr - f0), 32'd1);
    chk("brk_nbrk",    32'(n_brk - b0), 32'd1);
    chk("brk_samecyc", 32'(n_brk_ferr - bf0), 32'd1);
    chk("brk_nvalid",  32'(n_valid - v0), 32'd0);
    chk("brk_busy",    32'(rx_if.o_busy), 32'd0);
    send_frame(8'h41, 1'b1, -1, 1'b1);
    send_bit(1'b1, 100);
    chk("brk_41_nvalid", 32'(n_valid - v0), 32'd1);
    chk("brk_41_data",   32'(rx_if.o_data), 32'h41);

    // back-to-back frames
    snap();
    send_frame(8'h00, 1'b1, -1, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 1'b1);
    send_bit(1'b1, 100);
    chk("b2b_nvalid", 32'(n_valid - v0), 32'd2);
`ifdef UART_RX_PARITY_EN
    chk("b2b_spacing", 32'(last_valid - prev_valid), 32'd1760);
`else
    chk("b2b_spacing", 32'(last_valid - prev_valid), 32'd1600);
`endif
    chk("b2b_data",   32'(rx_if.o_data), 32'hFF);

    // reset mid-frame (during data bit 4 of 0x3C)
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i), BIT);
    send_bit(1'b1, 80);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_data",  32'(rx_if.o_data), 32'h00);
    chk("mr_busy",  32'(rx_if.o_busy), 32'd0);
    chk("mr_valid", 32'(rx_if.o_valid), 32'd0);
    rst_n = 1'b1;
    snap();
    send_bit(1'b1, 12*BIT);
    chk("mr_nvalid_idle", 32'(n_valid - v0), 32'd0);
    chk("mr_nferr_idle",  32'(n_ferr - f0), 32'd0);
    send_frame(8'h7A, 1'b1, -1, 1'b1);
    send_bit(1'b1, 100);
    chk("mr_7a_nvalid", 32'(n_valid - v0), 32'd1);
    chk("mr_7a_data",   32'(rx_if.o_data), 32'h7A);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h61, 1'b1, -1, 1'b0);
    send_bit(1'b1, 100);
    chk("par_nvalid",    32'(n_valid - v0), 32'd1);
    chk("par_err_valid", 32'(n_perr_valid - p0), 32'd1);
    chk("par_data",      32'(rx_if.o_data), 32'h61);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
